// File: rtl/bch_pkg.sv
// Shared BCH(63,51) constants and types for the encoder/decoder pair.
// Generator polynomial is given both in natural and in reciprocal (shift-register) form.
package bch_pkg;

    localparam int unsigned BCH_N    = 63;
    localparam int unsigned BCH_K    = 51;
    localparam int unsigned BCH_NPAR = BCH_N - BCH_K;

    localparam logic [6:0]  GF_POLY  = 7'b1000011;
    localparam logic [12:0] BCH_GEN  = 13'h1539;
    localparam logic [11:0] BCH_GREV = 12'h395;

    typedef enum logic {
        ST_MSG,
        ST_PARITY
    } t_bch_enc_state;

    // One division step of the remainder register; fb is the incoming bit XOR the register MSB.
    function automatic logic [11:0] lfsr_step(input logic [11:0] r, input logic fb);
        return {r[10:0], 1'b0} ^ (fb ? BCH_GREV : 12'h000);
    endfunction

endpackage

// File: rtl/bch_parity_lfsr.sv
// 12-bit remainder register: divides the message by g*(x) while it streams in,
// then shifts the remainder out MSB-first as parity.
module bch_parity_lfsr
    import bch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic shift_msg,
    input  logic shift_par,
    input  logic din,
    output logic par_out
);

    logic [11:0] lfsr_q;
    logic [11:0] lfsr_d;

    // clr has priority so the final parity shift and the frame restart share one cycle.
    always_comb begin
        lfsr_d = lfsr_q;
        if (clr) begin
            lfsr_d = '0;
        end else if (shift_msg) begin
            lfsr_d = lfsr_step(lfsr_q, din ^ lfsr_q[11]);
        end else if (shift_par) begin
            lfsr_d = {lfsr_q[10:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign par_out = lfsr_q[11];

endmodule

// File: rtl/bch_encoder.sv
// Systematic serial BCH(63,51) encoder: 51 message bits pass straight through,
// followed by 12 parity bits, through a single valid/ready output register.
module bch_encoder
    import bch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_data,
    output logic in_ready,
    output logic out_valid,
    output logic out_data,
    output logic out_last,
    input  logic out_ready
);

    localparam logic [5:0] LAST_MSG_CNT = 6'(BCH_K - 1);
    localparam logic [5:0] LAST_PAR_CNT = 6'(BCH_NPAR - 1);

    t_bch_enc_state state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic           out_valid_q, out_valid_d;
    logic           out_data_q, out_data_d;
    logic           out_last_q, out_last_d;

    logic slot_free;
    logic in_ready_c;
    logic lfsr_clr;
    logic lfsr_shift_msg;
    logic lfsr_shift_par;
    logic par_bit;

    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_last_d     = out_last_q;
        in_ready_c     = 1'b0;
        lfsr_clr       = 1'b0;
        lfsr_shift_msg = 1'b0;
        lfsr_shift_par = 1'b0;

        case (state_q)
            ST_MSG: begin
                in_ready_c = slot_free && rst_n;
                if (in_valid && in_ready_c) begin
                    out_data_d     = in_data;
                    out_valid_d    = 1'b1;
                    out_last_d     = 1'b0;
                    lfsr_shift_msg = 1'b1;
                    if (cnt_q == LAST_MSG_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else if (slot_free) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end

            ST_PARITY: begin
                if (slot_free) begin
                    out_data_d     = par_bit;
                    out_valid_d    = 1'b1;
                    lfsr_shift_par = 1'b1;
                    if (cnt_q == LAST_PAR_CNT) begin
                        out_last_d = 1'b1;
                        cnt_d      = '0;
                        lfsr_clr   = 1'b1;
                        state_d    = ST_MSG;
                    end else begin
                        out_last_d = 1'b0;
                        cnt_d      = cnt_q + 6'd1;
                    end
                end
            end

            default: begin
                state_d = ST_MSG;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_MSG;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    bch_parity_lfsr u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (lfsr_clr),
        .shift_msg (lfsr_shift_msg),
        .shift_par (lfsr_shift_par),
        .din       (in_data),
        .par_out   (par_bit)
    );

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_bch_encoder.sv
// Directed bench for bch_encoder: hand-computed parity vectors, back-to-back frames,
// random stalls on both sides, and asynchronous reset mid-frame.
module tb_bch_encoder;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic in_data;
    logic in_ready;
    logic out_valid;
    logic out_data;
    logic out_last;
    logic out_ready;

    int total = 0;
    int bad   = 0;

    logic [50:0] fm [4];
    logic [11:0] fp [4];

    bch_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Streams n frames from fm/fp; pv/pr are percent chances of in_valid/out_ready per cycle.
    task automatic run_frames(input int n, input int pv, input int pr, input bit b2b);
        int   i = 0;
        int   o = 0;
        int   cyc = 0;
        int   nrdy = 0;
        int   first_v = -1;
        int   last_v = -1;
        int   f;
        int   j;
        logic expb;
        bit   stall_prev = 1'b0;
        logic pd = 1'b0;
        logic pl = 1'b0;
        while (o < n * 63 && cyc < 2000 * n) begin
            in_valid  = (i < n * 51) && ($urandom_range(99) < pv);
            in_data   = in_valid ? fm[i / 51][i % 51] : 1'($urandom_range(1));
            out_ready = ($urandom_range(99) < pr);
            #1;
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pd);
                chk("hold_last", out_last, pl);
            end
            if (out_valid) begin
                f = o / 63;
                j = o % 63;
                expb = (j < 51) ? fm[f][j] : fp[f][62 - j];
                chk("data", out_data, expb);
                chk("last", out_last, (j == 62) ? 1 : 0);
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (!in_ready) nrdy++;
            if (in_valid && in_ready) i++;
            if (out_valid && out_ready) o++;
            stall_prev = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("bits_out", o, n * 63);
        chk("bits_in", i, n * 51);
        if (b2b) begin
            chk("valid_span", last_v - first_v + 1, n * 63);
            chk("ready_low_cycles", nrdy, n * 12);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 1'b1;
        out_ready = 1'b1;
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_hold_valid", out_valid, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", in_ready, 1);
        chk("idle_valid", out_valid, 0);

        // all-zero message
        fm[0] = '0;
        fp[0] = 12'h000;
        run_frames(1, 100, 100, 1'b1);

        // impulse in the last message bit gives the generator tail
        fm[0] = 51'd1 << 50;
        fp[0] = 12'h395;
        run_frames(1, 100, 100, 1'b1);

        fm[0] = 51'd1 << 50;                   fp[0] = 12'h395;
        fm[1] = 51'd1 << 49;                   fp[1] = 12'h72A;
        fm[2] = (51'd1 << 49) | (51'd1 << 50); fp[2] = 12'h4BF;
        fm[3] = 51'd1 << 47;                   fp[3] = 12'hF3D;
        run_frames(4, 100, 100, 1'b1);

        run_frames(4, 50, 30, 1'b0);

        // asynchronous reset after 20 message bits
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("pre_rst_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_last", out_last, 0);
        chk("midrst_ready", in_ready, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fm[0] = 51'd1 << 50;
        fp[0] = 12'h395;
        run_frames(1, 100, 100, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
